phase_seq: RTL and testbench

Sequencer for the synth phase accumulator. Generates the 4-bit `phase_ctrl` command stream and the 16-bit `phase_data` increment word that drive the accumulator. Issues one advance command per sample period from an internal clock divider. Accepts new phase increments from the note/pitch logic over a valid/ready handshake and schedules each increment load into a free cycle.

---
 rtl/phase_seq.sv | 94 +++++++++
 tb/tb_phase_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_seq.sv
// phase_seq: command sequencer for the synth phase accumulator.
// It issues one advance per sample period, which comes from an internal
// divider. It also accepts phase increments over valid/ready into a
// one-entry buffer and issues each increment as a load command in the next
// cycle that carries no advance.
module phase_seq #(
  parameter int unsigned TICK_DIV = 1024  // clk cycles per sample period, 3..65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        inc_valid,
  input  logic [15:0] inc_data,
  output logic        inc_ready,
  output logic [3:0]  phase_ctrl,
  output logic [15:0] phase_data,
  output logic        sample_tick,
  output logic        load_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  // Each state is encoded with its accumulator command. The state register
  // therefore drives phase_ctrl directly, and phase_ctrl is a flop output.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_ADVANCE = 4'b0001,
    ST_LOAD    = 4'b1001
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            pend_valid;
  logic [15:0]     pend_data;
  logic            tick;

  assign tick       = enable && (cnt == CNT_LAST);
  assign inc_ready  = !pend_valid;
  assign phase_ctrl = state;

  // Sample-period divider: free-runs 0..TICK_DIV-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || (cnt == CNT_LAST)) begin
      // NOTE: state registers use non-blocking assignments, so every
      // always_ff block reads pre-edge values and simulation order cannot matter.
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Command FSM with its registered pulses, plus the one-entry increment buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sample_tick <= 1'b0;
      load_done   <= 1'b0;
      // NOTE: the data registers are reset along with the control registers.
      // phase_data is an output with a defined reset value of 0. Reset also
      // discards any pending increment.
      phase_data  <= '0;
      pend_data   <= '0;
      pend_valid  <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      load_done   <= 1'b0;

      // An advance has priority. A load that collides with it slips one cycle.
      if (tick) begin
        state       <= ST_ADVANCE;
        sample_tick <= 1'b1;
      end else if (pend_valid) begin
        state      <= ST_LOAD;
        load_done  <= 1'b1;
        phase_data <= pend_data;
      end else begin
        state <= ST_IDLE;
      end

      // Capture is possible only while the buffer is empty. The buffer drains
      // on the edge where its entry moves into LOAD.
      if (inc_valid && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= inc_data;
      end else if (pend_valid && !tick) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phase_seq.sv
// Testbench for phase_seq with TICK_DIV=4.
// A queue-based reference model predicts every output on every cycle, and
// directed sequences pin key cycles to hand-computed values.
module tb_phase_seq;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        inc_valid;
  logic [15:0] inc_data;
  logic        inc_ready;
  logic [3:0]  phase_ctrl;
  logic [15:0] phase_data;
  logic        sample_tick;
  logic        load_done;

  int total = 0;
  int bad   = 0;

  phase_seq #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .inc_valid   (inc_valid),
    .inc_data    (inc_data),
    .inc_ready   (inc_ready),
    .phase_ctrl  (phase_ctrl),
    .phase_data  (phase_data),
    .sample_tick (sample_tick),
    .load_done   (load_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model counts consecutive enabled edges. Every TD-th enabled edge
  // issues an advance. Any other edge issues a load if an increment waits in
  // the queue. The queue accepts a new increment only while it is empty.
  int          en_run;
  logic [15:0] q[$];
  logic [3:0]  m_ctrl;
  logic [15:0] m_data;
  logic        m_tick, m_done;
  bit          m_tick_now, m_had, m_accept;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      en_run = 0; q.delete();
      m_ctrl = 4'b0000; m_data = 16'h0; m_tick = 1'b0; m_done = 1'b0;
    end else begin
      m_tick_now = enable && (((en_run + 1) % TD) == 0);
      m_had      = (q.size() > 0);
      m_accept   = inc_valid && !m_had;
      en_run     = enable ? en_run + 1 : 0;
      m_tick = 1'b0; m_done = 1'b0;
      if (m_tick_now) begin
        m_ctrl = 4'b0001; m_tick = 1'b1;
      end else if (m_had) begin
        m_ctrl = 4'b1001; m_done = 1'b1; m_data = q.pop_front();
      end else begin
        m_ctrl = 4'b0000;
      end
      if (m_accept) q.push_back(inc_data);
    end
  end

  // ---------------- per-cycle compare + load monitor ----------------
  logic [15:0] dut_loads[$];
  bit          beef_seen = 1'b0;

  always @(posedge clk) begin
    #1;
    check("ctrl",  phase_ctrl,  m_ctrl);
    check("data",  phase_data,  m_data);
    check("tick",  sample_tick, m_tick);
    check("done",  load_done,   m_done);
    check("ready", inc_ready,   (q.size() == 0));
    if (load_done) begin
      dut_loads.push_back(phase_data);
      if (phase_data == 16'hBEEF) beef_seen = 1'b1;
    end
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n0;
    int guard;
    reset = 1'b1; enable = 1'b0; inc_valid = 1'b0; inc_data = 16'h0;
    repeat (3) @(negedge clk);

    // Reset values while reset is held.
    check("rst_ctrl",  phase_ctrl,  4'b0000);
    check("rst_data",  phase_data,  16'h0);
    check("rst_tick",  sample_tick, 1'b0);
    check("rst_done",  load_done,   1'b0);
    check("rst_ready", inc_ready,   1'b1);

    // Tick period: an advance on every 4th enabled edge.
    reset = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      check("period_tick", sample_tick, (i % TD) == 0);
      check("period_ctrl", phase_ctrl, ((i % TD) == 0) ? 4'b0001 : 4'b0000);
    end
    @(negedge clk) enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("disabled_tick", sample_tick, 1'b0);
    end
    @(negedge clk) enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check("resume_tick", sample_tick, (i % TD) == 0);
    end

    // Load latency in an idle window.
    @(negedge clk) enable = 1'b0;
    @(negedge clk) begin inc_valid = 1'b1; inc_data = 16'h1234; end
    @(posedge clk); #1;
    check("e0_ready", inc_ready, 1'b0);
    check("e0_ctrl",  phase_ctrl, 4'b0000);
    @(negedge clk) inc_valid = 1'b0;
    @(posedge clk); #1;
    check("e1_ctrl", phase_ctrl, 4'b1001);
    check("e1_data", phase_data, 16'h1234);
    check("e1_done", load_done,  1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("hold_data", phase_data, 16'h1234);
    check("hold_ctrl", phase_ctrl, 4'b0000);

    // Collision: the load's E1 is a tick edge, so the load slips one cycle.
    @(negedge clk) enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) begin inc_valid = 1'b1; inc_data = 16'hABCD; end
    @(posedge clk); #1;
    check("col_accept", inc_ready, 1'b0);
    @(negedge clk) inc_valid = 1'b0;
    @(posedge clk); #1;
    check("col_adv",  phase_ctrl, 4'b0001);
    check("col_tick", sample_tick, 1'b1);
    @(posedge clk); #1;
    check("col_load", phase_ctrl, 4'b1001);
    check("col_data", phase_data, 16'hABCD);
    @(posedge clk); #1;
    check("col_after", phase_ctrl, 4'b0000);
    @(negedge clk) enable = 1'b0;

    // Back-pressure: valid held high. Data offered while the buffer is full must be ignored.
    n0 = dut_loads.size();
    @(negedge clk) inc_valid = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      guard = 0;
      while (!inc_ready && guard < 8) begin
        inc_data = 16'hDEAD;
        @(negedge clk);
        guard++;
      end
      check("bp_wait", guard < 8, 1'b1);
      inc_data = 16'(v);
      @(negedge clk);
    end
    inc_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_count", dut_loads.size(), n0 + 3);
    if (dut_loads.size() >= n0 + 3) begin
      check("bp_first",  dut_loads[n0],     16'h0001);
      check("bp_second", dut_loads[n0 + 1], 16'h0002);
      check("bp_third",  dut_loads[n0 + 2], 16'h0003);
    end

    // Reset mid-operation: the accepted 16'hBEEF must never load.
    @(negedge clk) begin inc_valid = 1'b1; inc_data = 16'hBEEF; end
    @(posedge clk); #2;
    inc_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", inc_ready,  1'b1);
    check("mid_rst_data",  phase_data, 16'h0);
    check("mid_rst_ctrl",  phase_ctrl, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0; enable = 1'b1;
    for (int i = 1; i <= TD; i++) begin
      @(posedge clk); #1;
      check("post_rst_ctrl", phase_ctrl, (i == TD) ? 4'b0001 : 4'b0000);
      check("post_rst_data", phase_data, 16'h0);
    end
    repeat (6) @(posedge clk);
    #1;
    check("beef_never", beef_seen, 1'b0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
